// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access unit and its lane helper.
//   SZ_*      : access size encodings (11 is reserved and handled as a word)
//   state_e   : access FSM states
//   is_aligned: natural-alignment test for a size / address-offset pair
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_lane.sv
// mem_lane: combinational byte-lane steering, shared with the fetch path.
//   addr_lo  in  2 : byte offset inside the word
//   size     in  2 : access size
//   sext     in  1 : sign-extend the load result
//   st_data  in 32 : store data before replication
//   ld_raw   in 32 : full word as returned by memory
//   aligned  out 1 : access is naturally aligned
//   be       out 4 : little-endian byte enables
//   wdata    out 32: store data replicated over all lanes
//   ld_data  out 32: selected lane, extended to 32 bits
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [15:0] shifted;

  always_comb begin
    aligned = is_aligned(size, addr_lo);
    // Bring the addressed lane down to bit 0 before extension.
    shifted = 16'(ld_raw >> {addr_lo, 3'b000});
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be      = 4'b0011 << addr_lo;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = ld_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: ME-stage load/store unit driving a req/ack data-memory port.
//   TIMEOUT           : stall cycles without dm_ack before a bus error
//   clock, reset_0    : rising-edge clock, async active-low reset
//   ans_me .. sext_me : ME-stage controls from the EX->ME register
//   dm_*              : data-memory request port
//   mo_me, wreg_out   : extended load data and gated write enable to ME->WB
//   stall             : pipeline freeze while an access is outstanding
//   misalign, bus_err : one-cycle error pulses
//
// state | meaning
// IDLE  | no access outstanding; an aligned access issues its request here
// WAIT  | request held on the bus, counting stall cycles until ack/timeout
// RESP  | ME->WB captures the extended buffer (or the error result)
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic [31:0] ans_me,
  input  logic [31:0] st_me,
  input  logic [4:0]  rw_me,
  input  logic        wreg_me,
  input  logic        rmem_me,
  input  logic        wmem_me,
  input  logic [1:0]  size_me,
  input  logic        sext_me,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] mo_me,
  output logic        wreg_out,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic          err_q, err_d;

  logic          req_c, stall_c;
  logic          access, aligned;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata, ld_data;

  // The destination register travels in the ME->WB register; nothing here needs it.
  logic unused_rw;
  assign unused_rw = ^rw_me;

  assign access = rmem_me | wmem_me;

  mem_lane u_lane (
    .addr_lo (ans_me[1:0]),
    .size    (size_me),
    .sext    (sext_me),
    .st_data (st_me),
    .ld_raw  (buf_q),
    .aligned (aligned),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .ld_data (ld_data)
  );

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    err_d    = err_q;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    mo_me    = '0;
    wreg_out = wreg_me;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (!aligned) begin
            misalign = 1'b1;
            wreg_out = 1'b0;
          end else begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            err_d   = 1'b0;
            // The IDLE request cycle is the first stall cycle of the timeout window.
            cnt_d   = CW'(1);
            if (dm_ack) begin
              buf_d   = dm_rdata;
              state_d = RESP;
            end else if (TIMEOUT <= 1) begin
              err_d   = 1'b1;
              state_d = RESP;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end

      WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        // An ack in the last window cycle still wins over the timeout.
        if (dm_ack) begin
          buf_d   = dm_rdata;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (err_q) begin
          bus_err  = 1'b1;
          wreg_out = 1'b0;
        end else if (!wmem_me) begin
          mo_me = ld_data;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Gating with reset_0 drops the request immediately when reset hits mid-access,
  // even though the held inputs would otherwise re-request from IDLE.
  assign dm_req   = req_c & reset_0;
  assign stall    = stall_c & reset_0;
  assign dm_we    = dm_req & wmem_me;
  assign dm_be    = dm_req ? lane_be : 4'b0000;
  assign dm_addr  = {ans_me[31:2], 2'b00};
  assign dm_wdata = lane_wdata;

endmodule
